// File: rtl/llsc_mem_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | llsc_mem_unit : MEM-stage LL/SC controller feeding the LLbit register     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module llsc_mem_unit #(
   parameter int ADDR_W   = 32,
   parameter int LINK_LSB = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              flush_cause_i,
   input  logic              mem_valid_i,
   input  logic              mem_is_ll_i,
   input  logic              mem_is_sc_i,
   input  logic              mem_is_store_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic              llbit_cur_i,
   output logic              sc_success_o,
   output logic              sc_store_en_o,
   output logic              wb_llbit_we_o,
   output logic              wb_llbit_value_o,
   output logic [ADDR_W-1:0] link_addr_o
);

   localparam int TAG_W = ADDR_W - LINK_LSB;

   logic             wb_we_q,  wb_we_d;
   logic             wb_val_q, wb_val_d;
   logic [TAG_W-1:0] link_q,   link_d;

   logic w_act, w_eff, w_match;
   // The exception/other distinction only matters to the LLbit register itself.
   logic unused_ok;

   assign unused_ok = ^{flush_cause_i, mem_addr_i[LINK_LSB-1:0]};

   assign w_act   = mem_valid_i & ~stall_i & ~flush_i;
   assign w_eff   = wb_we_q ? wb_val_q : llbit_cur_i;
   assign w_match = (mem_addr_i[ADDR_W-1:LINK_LSB] == link_q);

   assign sc_success_o  = mem_valid_i & mem_is_sc_i & w_eff & w_match;
   assign sc_store_en_o = sc_success_o & ~stall_i & ~flush_i;

   always_comb begin
      wb_we_d  = 1'b0;
      wb_val_d = wb_val_q;
      link_d   = link_q;
      if (flush_i || stall_i) begin
         wb_we_d = 1'b0;
      end else if (w_act && mem_is_ll_i) begin
         wb_we_d  = 1'b1;
         wb_val_d = 1'b1;
         link_d   = mem_addr_i[ADDR_W-1:LINK_LSB];
      end else if (w_act && mem_is_sc_i) begin
         wb_we_d  = 1'b1;
         wb_val_d = 1'b0;
      end else if (w_act && mem_is_store_i && w_match && w_eff) begin
         wb_we_d  = 1'b1;
         wb_val_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we_q  <= 1'b0;
         wb_val_q <= 1'b0;
         link_q   <= '0;
      end else begin
         wb_we_q  <= wb_we_d;
         wb_val_q <= wb_val_d;
         link_q   <= link_d;
      end
   end

   assign wb_llbit_we_o    = wb_we_q;
   assign wb_llbit_value_o = wb_val_q;
   assign link_addr_o      = {link_q, {LINK_LSB{1'b0}}};

endmodule
`default_nettype wire

// File: tb/tb_llsc_mem_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_llsc_mem_unit : directed self-checking bench for llsc_mem_unit         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_llsc_mem_unit;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall, flush, flush_cause;
   logic              mem_valid, mem_is_ll, mem_is_sc, mem_is_store;
   logic [ADDR_W-1:0] mem_addr;
   logic              llbit_cur;
   logic              sc_success, sc_store_en, wb_llbit_we, wb_llbit_value;
   logic [ADDR_W-1:0] link_addr;

   int n_tests = 0;
   int n_fail  = 0;

   llsc_mem_unit #(.ADDR_W(ADDR_W), .LINK_LSB(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall),
      .flush_i          (flush),
      .flush_cause_i    (flush_cause),
      .mem_valid_i      (mem_valid),
      .mem_is_ll_i      (mem_is_ll),
      .mem_is_sc_i      (mem_is_sc),
      .mem_is_store_i   (mem_is_store),
      .mem_addr_i       (mem_addr),
      .llbit_cur_i      (llbit_cur),
      .sc_success_o     (sc_success),
      .sc_store_en_o    (sc_store_en),
      .wb_llbit_we_o    (wb_llbit_we),
      .wb_llbit_value_o (wb_llbit_value),
      .link_addr_o      (link_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; flush = 0; flush_cause = 0;
      mem_valid = 0; mem_is_ll = 0; mem_is_sc = 0; mem_is_store = 0;
      mem_addr = '0;
   endtask

   task automatic drive(input logic ll, input logic sc, input logic st, input logic [31:0] a);
      mem_valid = 1; mem_is_ll = ll; mem_is_sc = sc; mem_is_store = st; mem_addr = a;
      #1;
   endtask

   initial begin
      idle();
      llbit_cur = 0;
      rst = 1;
      drive(1, 0, 0, 32'h0000_1000);
      tick(); tick();
      rst = 0;
      idle();
      #1;
      check("rst_we",   wb_llbit_we,    0);
      check("rst_val",  wb_llbit_value, 0);
      check("rst_link", link_addr,      0);

      // LL then SC on the next cycle, LLbit register not yet updated
      drive(1, 0, 0, 32'h0000_1000);
      tick();
      check("ll_we",   wb_llbit_we,    1);
      check("ll_val",  wb_llbit_value, 1);
      check("ll_link", link_addr,      32'h0000_1000);
      llbit_cur = 0;
      drive(0, 1, 0, 32'h0000_1004);
      check("fwd_sc_ok", sc_success,  1);
      check("fwd_sc_en", sc_store_en, 1);
      tick();
      check("sc_wb_we",  wb_llbit_we,    1);
      check("sc_wb_val", wb_llbit_value, 0);
      idle();

      // SC outside the linked granule
      drive(1, 0, 0, 32'h0000_1000);
      tick();
      llbit_cur = 1;
      drive(0, 1, 0, 32'h0000_1010);
      check("miss_sc_ok", sc_success,  0);
      check("miss_sc_en", sc_store_en, 0);
      tick();
      check("miss_wb_we",  wb_llbit_we,    1);
      check("miss_wb_val", wb_llbit_value, 0);
      idle();

      // Ordinary store to the granule breaks the link
      llbit_cur = 0;
      drive(1, 0, 0, 32'h0000_2000);
      tick();
      check("ll2_link", link_addr, 32'h0000_2000);
      drive(0, 0, 1, 32'h0000_200C);
      tick();
      check("sw_wb_we",  wb_llbit_we,    1);
      check("sw_wb_val", wb_llbit_value, 0);
      llbit_cur = 1;
      drive(0, 1, 0, 32'h0000_2000);
      check("sw_sc_ok", sc_success,  0);
      check("sw_sc_en", sc_store_en, 0);
      tick();
      idle();

      // Stalled SC
      llbit_cur = 0;
      drive(1, 0, 0, 32'h0000_1000);
      tick();
      idle();
      llbit_cur = 1;
      tick();
      check("pre_stall_we", wb_llbit_we, 0);
      stall = 1;
      drive(0, 1, 0, 32'h0000_1000);
      for (int i = 0; i < 3; i++) begin
         check("stall_sc_ok", sc_success,  1);
         check("stall_sc_en", sc_store_en, 0);
         tick();
         check("stall_we", wb_llbit_we, 0);
      end
      stall = 0;
      #1;
      check("rel_sc_en", sc_store_en, 1);
      tick();
      check("rel_wb_we",  wb_llbit_we,    1);
      check("rel_wb_val", wb_llbit_value, 0);
      idle();
      #1;
      check("rel_after_en", sc_store_en, 0);
      tick();

      // Flushed LL leaves link and WB untouched
      flush = 1; flush_cause = 1;
      drive(1, 0, 0, 32'h0000_3000);
      tick();
      check("fl_we",   wb_llbit_we, 0);
      check("fl_link", link_addr,   32'h0000_1000);
      idle();
      llbit_cur = 0;
      drive(0, 1, 0, 32'h0000_3000);
      check("fl_sc_ok", sc_success,  0);
      check("fl_sc_en", sc_store_en, 0);
      tick();
      idle();

      // Reset in the middle of a sequence
      drive(1, 0, 0, 32'h0000_4000);
      tick();
      rst = 1;
      idle();
      tick();
      rst = 0;
      llbit_cur = 0;
      check("mid_rst_we",   wb_llbit_we, 0);
      check("mid_rst_link", link_addr,   0);
      drive(0, 1, 0, 32'h0000_4000);
      check("mid_rst_sc", sc_success, 0);
      tick();
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/llsc_mem_unit.md
Name: llsc_mem_unit

Overview:
- MEM-stage load-linked/store-conditional controller, directly upstream of the LLbit register.
- Decides SC success from the effective LLbit and the link granule. It gates the SC store to the data cache and produces the registered LLbit write request (WB stage) that the LLbit register consumes.
- Holds the link address.
- Forwards the in-flight WB write so back-to-back LL/SC sequences resolve correctly.

Parameters:
- ADDR_W, 32, width of the physical data address.
- LINK_LSB, 4, low address bits ignored for link matching (granule = 2^LINK_LSB bytes).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  MEM stage held this cycle
- flush  in  1  pipeline flush
- flush_cause  in  1  1 = exception/ERET flush, 0 = other flush
- mem_valid  in  1  valid instruction in MEM
- mem_is_ll  in  1  instruction is LL
- mem_is_sc  in  1  instruction is SC
- mem_is_store  in  1  ordinary store (SB/SH/SW/SWL/SWR), excludes SC
- mem_addr  in  ADDR_W  physical data address
- llbit_cur  in  1  current output of the LLbit register
- sc_success  out  1  combinational; SC result written to rt (1 = success)
- sc_store_en  out  1  combinational; SC may issue its store
- wb_llbit_we  out  1  registered LLbit write enable to the LLbit register
- wb_llbit_value  out  1  registered LLbit write data
- link_addr  out  ADDR_W  registered link address, low LINK_LSB bits zero

Behaviour:
- Reset (rst=1 at posedge):
  - wb_llbit_we=0, wb_llbit_value=0, link_addr=0.
  - Reset has priority over every other input.
- Qualified instruction: act = mem_valid & ~stall & ~flush.
- Effective LLbit (combinational): eff = wb_llbit_we ? wb_llbit_value : llbit_cur.
  - This forwards the write still in WB, which becomes visible in the LLbit register one cycle later.
- Link match: match = (mem_addr[ADDR_W-1:LINK_LSB] == link_addr[ADDR_W-1:LINK_LSB]).
- SC decision (combinational, MEM cycle):
  - sc_success = mem_valid & mem_is_sc & eff & match.
  - sc_store_en = sc_success & ~stall & ~flush.
  - A failed SC never reaches the cache.
  - sc_success may toggle while stalled; the consumer samples it only on the non-stalled cycle.
- WB register update at posedge, priority high to low:
  - flush (either cause): wb_llbit_we<=0; link_addr unchanged. An exception flush clears the LLbit register itself.
  - stall: wb_llbit_we<=0 (bubble); link_addr held.
  - act & mem_is_ll: wb_llbit_we<=1, wb_llbit_value<=1, link_addr<={mem_addr[ADDR_W-1:LINK_LSB], zeros}.
  - act & mem_is_sc: wb_llbit_we<=1, wb_llbit_value<=0. This applies whether the SC succeeds or fails.
  - act & mem_is_store & match & eff: wb_llbit_we<=1, wb_llbit_value<=0. A store to the linked granule breaks the link.
  - otherwise: wb_llbit_we<=0.
- mem_is_ll, mem_is_sc and mem_is_store are mutually exclusive. If more than one is set, LL > SC > store priority applies.
- Latency:
  - LL in MEM at cycle t gives wb_llbit_we=1 during t+1; the LLbit register reads 1 from t+2.
  - An SC in MEM at t+1 already sees eff=1 via forwarding.
- Reset mid-sequence drops any pending WB write and the link address. A later SC fails unless it is preceded by a new LL.
- No internal state depends on llbit_cur except through eff. link_addr is never cleared except by reset; validity is carried solely by the LLbit.

Test Plan:
- Reset: assert rst 2 cycles with mem_valid=1, mem_is_ll=1 -> wb_llbit_we=0, wb_llbit_value=0, link_addr=0 after release.
- LL @0x1000 at t, SC @0x1004 at t+1 (llbit_cur still 0) -> forwarding gives sc_success=1, sc_store_en=1 at t+1; at t+2 wb_llbit_we=1, wb_llbit_value=0; link_addr=0x1000.
- LL @0x1000, then SC @0x1010 with llbit_cur=1 -> match=0, sc_success=0, sc_store_en=0, wb write 0 next cycle.
- LL @0x2000, ordinary SW @0x200C, then SC @0x2000 -> SW produces wb write 0; SC one cycle later sees eff=0, sc_success=0.
- SC @0x1000 with eff=1 and stall=1 for 3 cycles -> sc_success=1 but sc_store_en=0 and wb_llbit_we=0 during the stall; on release sc_store_en=1 for one cycle, wb write 0 next cycle.
- LL in MEM with flush=1, flush_cause=1 -> wb_llbit_we=0 and link_addr unchanged next cycle; following SC with llbit_cur=0 fails.
